// File: rtl/flex_counter_pkg.sv
// Shared types for the up/down flex counter: step direction and range-end behaviour.
package flex_counter_pkg;

    localparam int DEFAULT_SIZE = 4;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } cnt_dir_t;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } cnt_mode_t;

endpackage

// File: rtl/flex_counter_nxt.sv
// Combinational next-count for one enabled step within the range [1, rollover_val],
// flagging when the step wrapped from one end of the range to the other.
module flex_counter_nxt
    import flex_counter_pkg::*;
#(
    parameter int SIZE = DEFAULT_SIZE
) (
    input  logic [SIZE-1:0] count,
    input  logic [SIZE-1:0] rollover_val,
    input  cnt_dir_t        dir,
    input  cnt_mode_t       mode,
    output logic [SIZE-1:0] nxt,
    output logic            wrapped
);

    localparam logic [SIZE-1:0] ONE = SIZE'(1);

    always_comb begin
        // NOTE: every output gets a default first so no path through the branches infers a latch.
        nxt     = count;
        wrapped = 1'b0;
        if (rollover_val == '0) begin
            nxt = '0;
        end else if (count == '0) begin
            nxt = (dir == DIR_UP) ? ONE : rollover_val;
        end else if (dir == DIR_UP) begin
            if (count < rollover_val) begin
                nxt = count + ONE;
            end else if (mode == MODE_WRAP) begin
                nxt     = ONE;
                wrapped = 1'b1;
            end else begin
                nxt = rollover_val;
            end
        end else begin
            // Counts above the bound fall back into range through plain decrement.
            if (count > ONE) begin
                nxt = count - ONE;
            end else if (mode == MODE_WRAP) begin
                nxt     = rollover_val;
                wrapped = 1'b1;
            end else begin
                nxt = ONE;
            end
        end
    end

endmodule

// File: rtl/flex_counter_ud.sv
// Up/down counter with clear/load priority, wrap or saturate mode, and registered
// rollover/min flags plus a one-cycle wrap pulse aligned with count_out.
module flex_counter_ud
    import flex_counter_pkg::*;
#(
    parameter int SIZE = DEFAULT_SIZE
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            clear,
    input  logic            count_enable,
    input  logic            count_up,
    input  logic            saturate,
    input  logic            load,
    input  logic [SIZE-1:0] load_val,
    input  logic [SIZE-1:0] rollover_val,
    output logic [SIZE-1:0] count_out,
    output logic            rollover_flag,
    output logic            min_flag,
    output logic            wrap_pulse
);

    localparam logic [SIZE-1:0] ONE = SIZE'(1);

    logic [SIZE-1:0] step_nxt;
    logic            step_wrapped;
    logic [SIZE-1:0] cnt_d;
    logic            wrap_d;
    logic            roll_d;
    logic            min_d;

    flex_counter_nxt #(.SIZE(SIZE)) u_nxt (
        .count        (count_out),
        .rollover_val (rollover_val),
        .dir          (cnt_dir_t'(count_up)),
        .mode         (cnt_mode_t'(saturate)),
        .nxt          (step_nxt),
        .wrapped      (step_wrapped)
    );

    always_comb begin
        cnt_d  = count_out;
        wrap_d = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (count_enable) begin
            cnt_d  = step_nxt;
            wrap_d = step_wrapped;
        end
    end

    // Flags are derived from the value about to be registered, so they line up with count_out.
    assign roll_d = (cnt_d == rollover_val) && (rollover_val != '0);
    assign min_d  = (cnt_d == ONE);

    always_ff @(posedge clk or negedge n_rst) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (!n_rst) begin
            count_out     <= '0;
            rollover_flag <= 1'b0;
            min_flag      <= 1'b0;
            wrap_pulse    <= 1'b0;
        end else begin
            count_out     <= cnt_d;
            rollover_flag <= roll_d;
            min_flag      <= min_d;
            wrap_pulse    <= wrap_d;
        end
    end

endmodule

// File: tb/tb_flex_counter_ud.sv
// Self-checking bench for flex_counter_ud (SIZE=4): directed vector table, hand-written
// reset/countdown sequences, and randomized stimulus against an arithmetic reference model.
module tb_flex_counter_ud;

    localparam int SIZE = 4;

    logic            tb_clk;
    logic            n_rst;
    logic            clear;
    logic            count_enable;
    logic            count_up;
    logic            saturate;
    logic            load;
    logic [SIZE-1:0] load_val;
    logic [SIZE-1:0] rollover_val;
    logic [SIZE-1:0] count_out;
    logic            rollover_flag;
    logic            min_flag;
    logic            wrap_pulse;

    int total;
    int bad;

    // Reference model state
    int m_cnt;
    bit m_ro;
    bit m_min;
    bit m_wr;

    typedef struct {
        string name;
        bit    clr;
        bit    ld;
        bit    en;
        bit    up;
        bit    sat;
        int    lval;
        int    rv;
        int    e_cnt;
        bit    e_ro;
        bit    e_min;
        bit    e_wr;
    } vec_t;

    flex_counter_ud #(.SIZE(SIZE)) dut (
        .clk           (tb_clk),
        .n_rst         (n_rst),
        .clear         (clear),
        .count_enable  (count_enable),
        .count_up      (count_up),
        .saturate      (saturate),
        .load          (load),
        .load_val      (load_val),
        .rollover_val  (rollover_val),
        .count_out     (count_out),
        .rollover_flag (rollover_flag),
        .min_flag      (min_flag),
        .wrap_pulse    (wrap_pulse)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_all(input string name, input int e_cnt, input bit e_ro,
                             input bit e_min, input bit e_wr);
        check({name, ".count"}, int'(count_out), e_cnt);
        check({name, ".rollover"}, int'(rollover_flag), int'(e_ro));
        check({name, ".min"}, int'(min_flag), int'(e_min));
        check({name, ".wrap"}, int'(wrap_pulse), int'(e_wr));
    endtask

    // Inputs change 1 time unit after a rising edge; outputs sampled 1 unit after the next.
    task automatic drive(input bit clr, input bit ld, input bit en, input bit up,
                         input bit sat, input int lval, input int rv);
        clear        = clr;
        load         = ld;
        count_enable = en;
        count_up     = up;
        saturate     = sat;
        load_val     = SIZE'(lval);
        rollover_val = SIZE'(rv);
        @(posedge tb_clk);
        #1;
    endtask

    // Behavioural model: range positions handled with modular arithmetic on [1, R].
    task automatic model_step(input bit clr, input bit ld, input bit en, input bit up,
                              input bit sat, input int lval, input int rv);
        m_wr = 1'b0;
        if (clr) begin
            m_cnt = 0;
        end else if (ld) begin
            m_cnt = lval;
        end else if (en) begin
            if (rv == 0) begin
                m_cnt = 0;
            end else if (m_cnt == 0) begin
                m_cnt = up ? 1 : rv;
            end else if (up) begin
                if (m_cnt >= rv && sat) m_cnt = rv;
                else if (m_cnt > rv) begin
                    m_cnt = 1;
                    m_wr  = 1'b1;
                end else begin
                    m_wr  = (m_cnt == rv);
                    m_cnt = (m_cnt % rv) + 1;
                end
            end else begin
                if (m_cnt > rv) m_cnt = m_cnt - 1;
                else if (m_cnt == 1 && sat) m_cnt = 1;
                else begin
                    m_wr  = (m_cnt == 1);
                    m_cnt = ((m_cnt - 2 + rv) % rv) + 1;
                end
            end
        end
        m_ro  = (rv != 0) && (m_cnt == rv);
        m_min = (m_cnt == 1);
    endtask

    vec_t vecs[$];

    initial begin
        total        = 0;
        bad          = 0;
        clear        = 1'b0;
        load         = 1'b0;
        count_enable = 1'b0;
        count_up     = 1'b1;
        saturate     = 1'b0;
        load_val     = '0;
        rollover_val = '0;
        n_rst        = 1'b0;

        // Reset state
        #12;
        check_all("reset", 0, 0, 0, 0);
        @(negedge tb_clk);
        n_rst = 1'b1;
        @(posedge tb_clk);
        #1;

        //        name          clr ld en up sat lval rv  cnt ro min wr
        vecs.push_back('{"upw_clr",   1, 0, 0, 1, 0,  0,  2,  0, 0, 0, 0});
        vecs.push_back('{"upw_1",     0, 0, 1, 1, 0,  0,  2,  1, 0, 1, 0});
        vecs.push_back('{"upw_2",     0, 0, 1, 1, 0,  0,  2,  2, 1, 0, 0});
        vecs.push_back('{"upw_wrap",  0, 0, 1, 1, 0,  0,  2,  1, 0, 1, 1});
        vecs.push_back('{"sat_clr",   1, 0, 0, 1, 1,  0,  3,  0, 0, 0, 0});
        vecs.push_back('{"sat_u1",    0, 0, 1, 1, 1,  0,  3,  1, 0, 1, 0});
        vecs.push_back('{"sat_u2",    0, 0, 1, 1, 1,  0,  3,  2, 0, 0, 0});
        vecs.push_back('{"sat_u3",    0, 0, 1, 1, 1,  0,  3,  3, 1, 0, 0});
        vecs.push_back('{"sat_u3b",   0, 0, 1, 1, 1,  0,  3,  3, 1, 0, 0});
        vecs.push_back('{"sat_d2",    0, 0, 1, 0, 1,  0,  3,  2, 0, 0, 0});
        vecs.push_back('{"sat_d1",    0, 0, 1, 0, 1,  0,  3,  1, 0, 1, 0});
        vecs.push_back('{"sat_d1b",   0, 0, 1, 0, 1,  0,  3,  1, 0, 1, 0});
        vecs.push_back('{"pri_clr",   1, 1, 1, 1, 0,  5,  8,  0, 0, 0, 0});
        vecs.push_back('{"pri_ld",    0, 1, 1, 1, 0,  5,  8,  5, 0, 0, 0});
        vecs.push_back('{"pri_up",    0, 0, 1, 1, 0,  5,  8,  6, 0, 0, 0});
        vecs.push_back('{"hold_reev", 0, 0, 0, 1, 0,  5,  6,  6, 1, 0, 0});
        vecs.push_back('{"r1_clr",    1, 0, 0, 1, 0,  0,  1,  0, 0, 0, 0});
        vecs.push_back('{"r1_first",  0, 0, 1, 1, 0,  0,  1,  1, 1, 1, 0});
        vecs.push_back('{"r1_wrap_a", 0, 0, 1, 1, 0,  0,  1,  1, 1, 1, 1});
        vecs.push_back('{"r1_wrap_b", 0, 0, 1, 1, 0,  0,  1,  1, 1, 1, 1});
        vecs.push_back('{"ld12",      0, 1, 0, 1, 0, 12,  8, 12, 0, 0, 0});
        vecs.push_back('{"ld12_up",   0, 0, 1, 1, 0,  0,  8,  1, 0, 1, 1});
        vecs.push_back('{"r0_up",     0, 0, 1, 1, 0,  0,  0,  0, 0, 0, 0});
        vecs.push_back('{"r0_dn",     0, 0, 1, 0, 0,  0,  0,  0, 0, 0, 0});
        vecs.push_back('{"dn_from0",  0, 0, 1, 0, 0,  0,  4,  4, 1, 0, 0});
        vecs.push_back('{"ld_hi",     0, 1, 0, 0, 1, 12,  4, 12, 0, 0, 0});
        vecs.push_back('{"dn_above",  0, 0, 1, 0, 1,  0,  4, 11, 0, 0, 0});
        vecs.push_back('{"ld_top",    0, 1, 1, 1, 0,  4,  4,  4, 1, 0, 0});
        vecs.push_back('{"top15_up",  0, 1, 0, 1, 0, 15, 15, 15, 1, 0, 0});
        vecs.push_back('{"top15_wr",  0, 0, 1, 1, 0,  0, 15,  1, 0, 1, 1});

        foreach (vecs[i]) begin
            drive(vecs[i].clr, vecs[i].ld, vecs[i].en, vecs[i].up, vecs[i].sat,
                  vecs[i].lval, vecs[i].rv);
            check_all(vecs[i].name, vecs[i].e_cnt, vecs[i].e_ro, vecs[i].e_min, vecs[i].e_wr);
        end

        // Down count from 0 with R=8: 8, 7..1, then wrap back to 8
        drive(1, 0, 0, 0, 0, 0, 8);
        check_all("dn_clr", 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 1, 0, 0, 0, 8);
            check_all($sformatf("dn_step%0d", i), 8 - i, i == 0, i == 7, 0);
        end
        drive(0, 0, 1, 0, 0, 0, 8);
        check_all("dn_wrap", 8, 1, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 8);
        check_all("dn_hold", 8, 1, 0, 0);

        // Async reset mid-count: reach 5, drop n_rst between edges
        drive(1, 0, 0, 1, 0, 0, 8);
        for (int i = 0; i < 5; i++) drive(0, 0, 1, 1, 0, 0, 8);
        check_all("pre_rst", 5, 0, 0, 0);
        #2;
        n_rst = 1'b0;
        #1;
        check_all("async_rst", 0, 0, 0, 0);
        @(negedge tb_clk);
        check_all("rst_held", 0, 0, 0, 0);
        n_rst = 1'b1;
        @(posedge tb_clk);
        #1;

        // Randomized stimulus against the reference model
        drive(1, 0, 0, 1, 0, 0, 8);
        model_step(1, 0, 0, 1, 0, 0, 8);
        for (int i = 0; i < 400; i++) begin
            bit r_clr, r_ld, r_en, r_up, r_sat;
            int r_lval, r_rv;
            r_clr  = ($urandom_range(0, 19) == 0);
            r_ld   = ($urandom_range(0, 9) == 0);
            r_en   = ($urandom_range(0, 3) != 0);
            r_up   = $urandom_range(0, 1);
            r_sat  = ($urandom_range(0, 3) == 0);
            r_lval = $urandom_range(0, 15);
            r_rv   = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 6);
            drive(r_clr, r_ld, r_en, r_up, r_sat, r_lval, r_rv);
            model_step(r_clr, r_ld, r_en, r_up, r_sat, r_lval, r_rv);
            check_all($sformatf("rnd%0d", i), m_cnt, m_ro, m_min, m_wr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
